// File: rtl/mmio_gpio_pkg.sv
// Shared register map constants for the memory-mapped GPIO controller.
package mmio_gpio_pkg;

  localparam logic [1:0] REG_OUT  = 2'd0;
  localparam logic [1:0] REG_DIR  = 2'd1;
  localparam logic [1:0] REG_IN   = 2'd2;
  localparam logic [1:0] REG_EDGE = 2'd3;

  localparam int MAX_PORTS = 16;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage input synchroniser; all stages clear to 0 on reset.
module gpio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: per-port OUT/DIR/IN/EDGE registers, sticky rising-edge
// flags gated by a post-reset warm-up, and a single unmasked interrupt.
module mmio_gpio
  import mmio_gpio_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_PORTS   = 4,
  parameter int SYNC_STAGES = 2,
  localparam int ADDR_W     = $clog2(NUM_PORTS) + 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sel,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           rdata,
  input  logic [NUM_PORTS*DATA_W-1:0] port_in,
  output logic [NUM_PORTS*DATA_W-1:0] port_out,
  output logic [NUM_PORTS*DATA_W-1:0] port_oe,
  output logic                        irq
);

  localparam int WARM_CYC = SYNC_STAGES + 1;
  localparam int WARM_W   = $clog2(WARM_CYC + 1);

  logic [DATA_W-1:0] out_q  [NUM_PORTS];
  logic [DATA_W-1:0] out_d  [NUM_PORTS];
  logic [DATA_W-1:0] dir_q  [NUM_PORTS];
  logic [DATA_W-1:0] dir_d  [NUM_PORTS];
  logic [DATA_W-1:0] edge_q [NUM_PORTS];
  logic [DATA_W-1:0] edge_d [NUM_PORTS];
  logic [DATA_W-1:0] prev_q [NUM_PORTS];
  logic [DATA_W-1:0] in_sync[NUM_PORTS];
  logic [DATA_W-1:0] rise   [NUM_PORTS];
  logic [DATA_W-1:0] clr    [NUM_PORTS];

  logic [NUM_PORTS-1:0] hit;
  logic [ADDR_W-1:0]    pidx;
  logic [1:0]           reg_sel;
  logic                 wr_en;
  logic                 rd_en;
  logic [WARM_W-1:0]    warm_q;
  logic [WARM_W-1:0]    warm_d;
  logic                 armed;

  assign pidx    = addr >> 2;
  assign reg_sel = addr[1:0];
  assign wr_en   = sel & we;
  assign rd_en   = sel & ~we;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    gpio_sync #(
      .WIDTH (DATA_W),
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .d_i    (port_in[p*DATA_W +: DATA_W]),
      .q_o    (in_sync[p])
    );
    assign port_out[p*DATA_W +: DATA_W] = out_q[p];
    assign port_oe[p*DATA_W +: DATA_W]  = dir_q[p];
  end

  // Out-of-range port indices match no port, so they read 0 and write nothing.
  always_comb begin
    hit = '0;
    for (int p = 0; p < NUM_PORTS; p++) hit[p] = (32'(pidx) == 32'(p));
  end

  // Levels already high at reset release must not look like rising edges.
  assign armed  = (warm_q == WARM_W'(WARM_CYC));
  assign warm_d = armed ? warm_q : warm_q + 1'b1;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      out_d[p] = out_q[p];
      dir_d[p] = dir_q[p];
      rise[p]  = in_sync[p] & ~prev_q[p] & {DATA_W{armed}};
      clr[p]   = '0;
      if (wr_en && hit[p]) begin
        case (reg_sel)
          REG_OUT:  out_d[p] = wdata;
          REG_DIR:  dir_d[p] = wdata;
          REG_EDGE: clr[p]   = wdata;
          default:  ;
        endcase
      end
      // A rise in the same cycle as a clear keeps the flag set.
      edge_d[p] = (edge_q[p] & ~clr[p]) | rise[p];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_q[p]  <= '0;
        dir_q[p]  <= '0;
        edge_q[p] <= '0;
        prev_q[p] <= '0;
      end
    end else begin
      warm_q <= warm_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_q[p]  <= out_d[p];
        dir_q[p]  <= dir_d[p];
        edge_q[p] <= edge_d[p];
        prev_q[p] <= in_sync[p];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (hit[p]) begin
          case (reg_sel)
            REG_OUT:  rdata = out_q[p];
            REG_DIR:  rdata = dir_q[p];
            REG_IN:   rdata = in_sync[p];
            REG_EDGE: rdata = edge_q[p];
          endcase
        end
      end
    end
  end

  always_comb begin
    irq = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) irq = irq | (|edge_q[p]);
  end

endmodule
